// File: rtl/inst_dispatch_v2.sv
// Instruction dispatcher: pops FWFT FIFO words, waits on dependency/exclusion/busy
// terms, and emits one-cycle configure pulses to compute or N_CH DMA channels.
module inst_dispatch_v2 #(
  parameter int              INST_LEN  = 256,
  parameter int              N_CH      = 4,
  parameter int              TYPE_LEN  = 4,
  parameter int              DEP_LEN   = N_CH + 1,
  parameter int              PAY_LEN   = INST_LEN - TYPE_LEN - DEP_LEN,
  parameter logic [N_CH-1:0] EXCL_MASK = {N_CH{1'b1}},
  parameter int              CNT_LEN   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  input  logic [INST_LEN-1:0] inst_data,
  output logic                inst_pop,
  input  logic                comp_idle,
  output logic                comp_conf,
  input  logic [N_CH-1:0]     ch_idle,
  output logic [N_CH-1:0]     ch_conf,
  output logic [2:0]          mem_sel,
  output logic [PAY_LEN-1:0]  payload,
  output logic                err_illegal,
  output logic [CNT_LEN-1:0]  stall_cnt
);

  localparam logic [0:0] S_EVAL  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]         r_state;
  logic               r_pop;
  logic               r_comp;
  logic [N_CH-1:0]    r_ch;
  logic [2:0]         r_mem_sel;
  logic [PAY_LEN-1:0] r_payload;
  logic               r_err;
  logic [CNT_LEN-1:0] r_stall;
  logic [N_CH-1:0]    r_pend;
  logic [1:0]         r_tmr [N_CH];
  logic               r_pend_c;
  logic [1:0]         r_tmr_c;

  logic [TYPE_LEN-1:0] w_type;
  logic [DEP_LEN-1:0]  w_dep;
  logic [PAY_LEN-1:0]  w_pay;
  logic [N_CH-1:0]     w_busy_ch;
  logic                w_busy_comp;
  logic [N_CH-1:0]     w_ch_hit;
  logic [2:0]          w_ch_idx;
  logic                w_is_comp, w_is_bar, w_is_ch, w_is_ill;
  logic                w_dep_ok, w_tgt_ok, w_allow;

  assign w_type      = inst_data[TYPE_LEN-1:0];
  assign w_dep       = inst_data[TYPE_LEN +: DEP_LEN];
  assign w_pay       = inst_data[INST_LEN-1 -: PAY_LEN];
  assign w_busy_ch   = ~ch_idle | r_pend;
  assign w_busy_comp = ~comp_idle | r_pend_c;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_ch_hit = '0;
    w_ch_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_type == TYPE_LEN'(k + 1)) begin
        w_ch_hit[k] = 1'b1;
        w_ch_idx    = 3'(k);
      end
    end
    w_is_comp = (w_type == '0);
    w_is_bar  = &w_type;
    w_is_ch   = |w_ch_hit;
    w_is_ill  = ~w_is_comp & ~w_is_ch & ~w_is_bar;
    w_dep_ok  = ~|(w_dep[N_CH-1:0] & w_busy_ch) & ~(w_dep[N_CH] & w_busy_comp);
    // An exclusive channel needs the whole shared-port group quiet, not just itself.
    w_tgt_ok  = ~|(w_ch_hit & w_busy_ch) &
                (~|(w_ch_hit & EXCL_MASK) | ~|(EXCL_MASK & w_busy_ch));
    w_allow   = inst_valid & (w_is_ill | (w_dep_ok &
                (w_is_comp ? ~w_busy_comp :
                 w_is_bar  ? (~|w_busy_ch & ~w_busy_comp) : w_tgt_ok)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EVAL;
      r_pop     <= 1'b0;
      r_comp    <= 1'b0;
      r_ch      <= '0;
      r_mem_sel <= '0;
      r_payload <= '0;
      r_err     <= 1'b0;
      r_stall   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_EVAL: begin
          if (w_allow) begin
            r_state <= S_ISSUE;
            r_pop   <= 1'b1;
            r_comp  <= w_is_comp;
            r_ch    <= w_ch_hit;
            if (w_is_ch) r_mem_sel <= w_ch_idx;
            if (w_is_ch || w_is_comp) r_payload <= w_pay;
            if (w_is_ill) r_err <= 1'b1;
          end else if (inst_valid && !(&r_stall)) begin
            r_stall <= r_stall + CNT_LEN'(1);
          end
        end
        default: begin
          r_state <= S_EVAL;
          r_pop   <= 1'b0;
          r_comp  <= 1'b0;
          r_ch    <= '0;
        end
      endcase
    end
  end

  // Pending bits cover idle-flag lag: cleared on first idle drop or after the timer runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_pend_c <= 1'b0;
      r_tmr_c  <= '0;
      for (int k = 0; k < N_CH; k++) r_tmr[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (ch_conf[k]) begin
          r_pend[k] <= 1'b1;
          r_tmr[k]  <= 2'd2;
        end else if (r_pend[k]) begin
          if (!ch_idle[k] || r_tmr[k] == 2'd0) r_pend[k] <= 1'b0;
          else                                 r_tmr[k]  <= r_tmr[k] - 2'd1;
        end
      end
      if (comp_conf) begin
        r_pend_c <= 1'b1;
        r_tmr_c  <= 2'd2;
      end else if (r_pend_c) begin
        if (!comp_idle || r_tmr_c == 2'd0) r_pend_c <= 1'b0;
        else                               r_tmr_c  <= r_tmr_c - 2'd1;
      end
    end
  end

  // Reset during ISSUE masks that cycle's strobes so the head word stays in the FIFO.
  assign inst_pop    = r_pop & ~rst;
  assign comp_conf   = r_comp & ~rst;
  assign ch_conf     = r_ch & {N_CH{~rst}};
  assign mem_sel     = r_mem_sel;
  assign payload     = r_payload;
  assign err_illegal = r_err;
  assign stall_cnt   = r_stall;

endmodule

// File: tb/tb_inst_dispatch_v2.sv
// Scoreboard bench for inst_dispatch_v2: stimulus pushes expected issues, a negedge
// monitor pops and compares whenever the DUT pulses.
module tb_inst_dispatch_v2;

  localparam int INST_LEN = 256;
  localparam int N_CH     = 4;
  localparam int TYPE_LEN = 4;
  localparam int DEP_LEN  = N_CH + 1;
  localparam int PAY_LEN  = INST_LEN - TYPE_LEN - DEP_LEN;

  typedef struct {
    logic [N_CH-1:0]    ch;
    logic               comp;
    logic [2:0]         mem_sel;
    logic [PAY_LEN-1:0] pay;
    logic               err;
    int                 cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                inst_valid;
  logic [INST_LEN-1:0] inst_data;
  logic                inst_pop;
  logic                comp_idle;
  logic                comp_conf;
  logic [N_CH-1:0]     ch_idle;
  logic [N_CH-1:0]     ch_conf;
  logic [2:0]          mem_sel;
  logic [PAY_LEN-1:0]  payload;
  logic                err_illegal;
  logic [31:0]         stall_cnt;

  logic                s_pop, s_comp, s_err;
  logic [N_CH-1:0]     s_ch;
  logic [2:0]          s_mem;
  logic [PAY_LEN-1:0]  s_pay;
  logic [1:0]          s_stall;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  inst_dispatch_v2 #(.INST_LEN(INST_LEN), .N_CH(N_CH), .TYPE_LEN(TYPE_LEN)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pop(inst_pop), .comp_idle(comp_idle), .comp_conf(comp_conf),
    .ch_idle(ch_idle), .ch_conf(ch_conf), .mem_sel(mem_sel), .payload(payload),
    .err_illegal(err_illegal), .stall_cnt(stall_cnt)
  );

  // Narrow stall counter copy to exercise saturation.
  inst_dispatch_v2 #(.INST_LEN(INST_LEN), .N_CH(N_CH), .TYPE_LEN(TYPE_LEN), .CNT_LEN(2)) dut_sat (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pop(s_pop), .comp_idle(comp_idle), .comp_conf(s_comp),
    .ch_idle(ch_idle), .ch_conf(s_ch), .mem_sel(s_mem), .payload(s_pay),
    .err_illegal(s_err), .stall_cnt(s_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PAY_LEN-1:0] mk_pay(input logic [31:0] s);
    logic [255:0] w;
    w = {8{s}};
    return w[PAY_LEN-1:0];
  endfunction

  function automatic logic [INST_LEN-1:0] mk(input logic [TYPE_LEN-1:0] t,
                                             input logic [DEP_LEN-1:0] d,
                                             input logic [PAY_LEN-1:0] p);
    return {p, d, t};
  endfunction

  function automatic exp_t mk_exp(input logic [N_CH-1:0] ch, input logic comp,
                                  input logic [2:0] ms, input logic [PAY_LEN-1:0] p,
                                  input logic err);
    exp_t e;
    e.ch = ch; e.comp = comp; e.mem_sel = ms; e.pay = p; e.err = err; e.cyc = 0;
    return e;
  endfunction

  // Monitor: any strobe must match the oldest expected issue, including its cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("pop_in_reset", {254'd0, inst_pop, comp_conf}, 256'd0);
      check("chconf_in_reset", ch_conf, 0);
    end else if (inst_pop || comp_conf || |ch_conf) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {inst_pop, comp_conf, ch_conf}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_cycle", cyc, e.cyc);
        check("inst_pop", inst_pop, 1);
        check("ch_conf", ch_conf, e.ch);
        check("comp_conf", comp_conf, e.comp);
        check("mem_sel", mem_sel, e.mem_sel);
        check("payload", payload, e.pay);
        check("err_illegal", err_illegal, e.err);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    inst_valid = 1'b0;
    comp_idle  = 1'b1;
    ch_idle    = '1;
    rst        = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  // Present one instruction; expect its ISSUE cycle 1+stall cycles from now.
  task automatic send(input logic [INST_LEN-1:0] inst, input exp_t e, input int stall);
    bit seen;
    seen  = 1'b0;
    e.cyc = cyc + 1 + stall;
    sb.push_back(e);
    inst_data  = inst;
    inst_valid = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (inst_pop) seen = 1'b1;
    end
    if (!seen) check("pop_timeout", inst_pop, 1);
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
  endtask

  initial begin
    logic [PAY_LEN-1:0] p1, p2, p3, p4, p5, p6, p7;
    p1 = mk_pay(32'hA5A5_0001); p2 = mk_pay(32'h1234_5678);
    p3 = mk_pay(32'hDEAD_BEEF); p4 = mk_pay(32'h0BAD_F00D);
    p5 = mk_pay(32'hCAFE_0005); p6 = mk_pay(32'h7777_0006);
    p7 = mk_pay(32'h5555_AAAA);

    // Reset held 3 cycles with a valid head word.
    rst = 1'b1; comp_idle = 1'b1; ch_idle = '1;
    inst_valid = 1'b1;
    inst_data  = mk(4'd2, 5'd0, p1);
    cycles(3);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_payload", payload, 0);
    check("rst_err", err_illegal, 0);
    check("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    send(mk(4'd2, 5'd0, p1), mk_exp(4'b0010, 1'b0, 3'd1, p1, 1'b0), 0);
    cycles(6);

    // Back-to-back compute: second waits out the pend timeout.
    do_reset();
    send(mk(4'd0, 5'd0, p2), mk_exp(4'b0000, 1'b1, 3'd0, p2, 1'b0), 0);
    send(mk(4'd0, 5'd0, p3), mk_exp(4'b0000, 1'b1, 3'd0, p3, 1'b0), 3);
    check("b2b_stall", stall_cnt, 3);
    check("b2b_stall_sat", s_stall, 3);
    cycles(6);

    // Exclusion: channel 1 waits on busy channel 0 in the shared-port group.
    do_reset();
    ch_idle = 4'b1110;
    fork
      send(mk(4'd2, 5'd0, p4), mk_exp(4'b0010, 1'b0, 3'd1, p4, 1'b0), 5);
      begin cycles(5); ch_idle[0] = 1'b1; end
    join
    check("excl_stall", stall_cnt, 5);
    check("excl_stall_sat", s_stall, 3);
    cycles(6);

    // Dependency: compute waits on channel 2 for 10 cycles.
    do_reset();
    ch_idle = 4'b1011;
    fork
      send(mk(4'd0, 5'b00100, p5), mk_exp(4'b0000, 1'b1, 3'd0, p5, 1'b0), 10);
      begin cycles(10); ch_idle[2] = 1'b1; end
    join
    check("dep_stall", stall_cnt, 10);
    check("dep_stall_sat", s_stall, 3);
    cycles(6);

    // Barrier: waits on channel 3 pend and compute busy; no conf, payload kept.
    do_reset();
    comp_idle = 1'b0;
    send(mk(4'd4, 5'd0, p6), mk_exp(4'b1000, 1'b0, 3'd3, p6, 1'b0), 0);
    fork
      send(mk(4'd15, 5'd0, p7), mk_exp(4'b0000, 1'b0, 3'd3, p6, 1'b0), 6);
      begin cycles(6); comp_idle = 1'b1; end
    join
    check("bar_stall", stall_cnt, 6);

    // Illegal: dropped at once despite blocked deps; sticky error; next dispatches.
    comp_idle = 1'b0;
    send(mk(4'd9, 5'b11111, p7), mk_exp(4'b0000, 1'b0, 3'd3, p6, 1'b1), 0);
    comp_idle = 1'b1;
    send(mk(4'd1, 5'd0, p2), mk_exp(4'b0001, 1'b0, 3'd0, p2, 1'b1), 0);
    cycles(6);
    check("ill_sticky", err_illegal, 1);
    check("ill_stall", stall_cnt, 6);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
